twiddle_fetch_seq: RTL and testbench

// - Requester side of the twiddle ROM interface. Walks the radix-2 DIT FFT in stage order, stage 0 to LOG2N-1, butterfly j = 0..N/2-1.
// - For each butterfly: computes k, reads the real part then the imaginary part from the single-port, 1-cycle-latency twiddle ROM.
// - Presents the {re, im} pair to the butterfly datapath over a valid/ready handshake.

---
 rtl/twiddle_fetch_seq.sv | 133 +++++++++++++
 tb/tb_twiddle_fetch_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_fetch_seq.sv
// twiddle_fetch_seq: requester side of the twiddle ROM. It walks every radix-2
// DIT butterfly in stage order (s = 0..LOG2N-1, j = 0..N/2-1). For each butterfly
// it fetches the cos and sin words from a single-port ROM with 1-cycle latency,
// then presents the {re, im} pair to the butterfly datapath over valid/ready.
module twiddle_fetch_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 32,
  parameter int LOG2N      = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [DATA_WIDTH-1:0]      rom_k,
  output logic                       rom_imag,
  input  logic [DATA_WIDTH-1:0]      rom_twiddle_in,
  output logic                       tw_valid,
  input  logic                       tw_ready,
  output logic [DATA_WIDTH-1:0]      tw_re,
  output logic [DATA_WIDTH-1:0]      tw_im,
  output logic [$clog2(LOG2N)-1:0]   tw_stage,
  output logic [LOG2N-2:0]           tw_index
);
  localparam int SW = $clog2(LOG2N);
  localparam int JW = LOG2N - 1;
  localparam logic [SW-1:0] LAST_S = SW'(LOG2N - 1);
  localparam logic [JW-1:0] LAST_J = JW'(N / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_RE,
    S_REQ_IM,
    S_CAP_IM,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t          state_reg;
  logic [SW-1:0]   s_reg;
  logic [JW-1:0]   j_reg;
  logic [JW-1:0]   j_mask;
  logic [JW-1:0]   k_val;

  // Mask that keeps the low s bits of j, i.e. j mod 2^s.
  for (genvar gi = 0; gi < JW; gi++) begin : g_mask
    assign j_mask[gi] = (int'(s_reg) > gi);
  end

  // Twiddle index: (j mod 2^s) scaled by the stage stride 2^(LOG2N-1-s).
  assign k_val = (j_reg & j_mask) << (JW - int'(s_reg));

  // ROM address and table select come from registered state only; idle states drive 0.
  always_comb begin
    rom_k    = '0;
    rom_imag = 1'b0;
    if (state_reg == S_REQ_RE || state_reg == S_REQ_IM) begin
      rom_k = DATA_WIDTH'(k_val);
    end
    if (state_reg == S_REQ_IM) begin
      rom_imag = 1'b1;
    end
  end

  // Sweep sequencer: request re, request im while capturing re, capture im, present.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      tw_valid  <= 1'b0;
      tw_re     <= '0;
      tw_im     <= '0;
      tw_stage  <= '0;
      tw_index  <= '0;
      s_reg     <= '0;
      j_reg     <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            s_reg     <= '0;
            j_reg     <= '0;
            busy      <= 1'b1;
            state_reg <= S_REQ_RE;
          end
        end
        S_REQ_RE: begin
          state_reg <= S_REQ_IM;
        end
        S_REQ_IM: begin
          // ROM data now holds the real word requested last cycle.
          tw_re     <= rom_twiddle_in;
          state_reg <= S_CAP_IM;
        end
        S_CAP_IM: begin
          tw_im     <= rom_twiddle_in;
          tw_stage  <= s_reg;
          tw_index  <= j_reg;
          tw_valid  <= 1'b1;
          state_reg <= S_PRESENT;
        end
        S_PRESENT: begin
          if (tw_valid && tw_ready) begin
            tw_valid <= 1'b0;
            if (j_reg == LAST_J) begin
              j_reg <= '0;
              if (s_reg == LAST_S) begin
                busy      <= 1'b0;
                done      <= 1'b1;
                state_reg <= S_DONE;
              end else begin
                s_reg     <= s_reg + 1'b1;
                state_reg <= S_REQ_RE;
              end
            end else begin
              j_reg     <= j_reg + 1'b1;
              state_reg <= S_REQ_RE;
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_fetch_seq.sv
// Testbench for twiddle_fetch_seq: registered ROM model, scoreboard of expected
// twiddle pairs and ROM requests, and a negedge monitor that checks every output.
module tb_twiddle_fetch_seq;
  localparam int DW     = 16;
  localparam int N      = 32;
  localparam int LOG2N  = 5;
  localparam int NPAIRS = LOG2N * N / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [DW-1:0] rom_k;
  logic          rom_imag;
  logic [DW-1:0] rom_twiddle_in;
  logic          tw_valid;
  logic          tw_ready;
  logic [DW-1:0] tw_re;
  logic [DW-1:0] tw_im;
  logic [2:0]    tw_stage;
  logic [3:0]    tw_index;

  always #5 clk = ~clk;

  twiddle_fetch_seq #(.DATA_WIDTH(DW), .N(N), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rom_k(rom_k), .rom_imag(rom_imag), .rom_twiddle_in(rom_twiddle_in),
    .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_re(tw_re), .tw_im(tw_im),
    .tw_stage(tw_stage), .tw_index(tw_index)
  );

  // Q1.15 twiddles: trunc(32768*cos(2*pi*k/N)), trunc(32768*sin(2*pi*k/N)), clamped
  logic [15:0] cos_tab [16] = '{16'h7fff, 16'h7d8a, 16'h7641, 16'h6a6d,
                                16'h5a82, 16'h471c, 16'h30fb, 16'h18f8,
                                16'h0000, 16'he708, 16'hcf05, 16'hb8e4,
                                16'ha57e, 16'h9593, 16'h89bf, 16'h8276};
  logic [15:0] sin_tab [16] = '{16'h0000, 16'h18f8, 16'h30fb, 16'h471c,
                                16'h5a82, 16'h6a6d, 16'h7641, 16'h7d8a,
                                16'h7fff, 16'h7d8a, 16'h7641, 16'h6a6d,
                                16'h5a82, 16'h471c, 16'h30fb, 16'h18f8};

  // ROM model with one cycle of registered latency
  always @(posedge clk)
    rom_twiddle_in <= rom_imag ? sin_tab[rom_k[3:0]] : cos_tab[rom_k[3:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int s; int j; logic [15:0] re; logic [15:0] im; } pair_t;
  typedef struct { int s; int j; int k; } kreq_t;
  pair_t exp_q[$];
  kreq_t k_q[$];

  int tests = 0;
  int fails = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference sweep: every stage, every butterfly, twiddle W_N^(j mod 2^s * N/2^(s+1))
  function automatic void load_model();
    exp_q.delete();
    k_q.delete();
    for (int s = 0; s < LOG2N; s++) begin
      for (int j = 0; j < N / 2; j++) begin
        int k;
        pair_t p;
        kreq_t r;
        k = (j % (1 << s)) * ((N / 2) >> s);
        p.s = s; p.j = j; p.re = cos_tab[k]; p.im = sin_tab[k];
        r.s = s; r.j = j; r.k = k;
        exp_q.push_back(p);
        k_q.push_back(r);
      end
    end
  endfunction

  // Monitor state (written only by the monitor)
  int          hs_count = 0;
  int          done_count = 0;
  int          start_cyc = 0;
  int          last_hs_cyc = 0;
  bit          first_pair = 0;
  bit          rst_prev = 0;
  bit          prev_valid = 0;
  bit          prev_done = 0;
  bit          stall_prev = 0;
  logic [38:0] held;
  logic [15:0] prev_rom_k = '0;
  logic        prev_rom_imag = 1'b0;
  int          tmo = 0;
  int          tmo_seen = 0;
  pair_t       e;
  kreq_t       kr;

  // Monitor: samples on the falling edge, pops the scoreboard on every handshake
  always @(negedge clk) begin
    if (tmo != tmo_seen) begin
      check("sweep_finished_within_budget", tmo, tmo_seen);
      tmo_seen = tmo;
    end
    if (rst_prev) begin
      check("rst_ctrl", {busy, done, tw_valid, rom_imag, tw_stage, tw_index}, 0);
      check("rst_rom_k_re", {rom_k, tw_re}, 0);
      check("rst_im", tw_im, 0);
    end
    if (rst) begin
      exp_q.delete();
      k_q.delete();
      hs_count = 0;
      first_pair = 0;
      prev_valid = 0;
      prev_done = 0;
      stall_prev = 0;
    end else begin
      if (start && !busy && !done && !tw_valid) begin
        load_model();
        start_cyc = cyc;
        first_pair = 1;
        hs_count = 0;
      end
      if (rom_imag) begin
        check("rom_re_then_im", {prev_rom_imag, prev_rom_k}, {1'b0, rom_k});
        if (k_q.size() == 0) begin
          check("rom_request_count", k_q.size(), 1);
        end else begin
          kr = k_q.pop_front();
          check("rom_k", rom_k, kr.k);
          if (kr.s == 3 && kr.j == 5) check("spot_k_s3j5", rom_k, 10);
          if (kr.s == 1 && kr.j == 3) check("spot_k_s1j3", rom_k, 8);
          if (kr.s == 4 && kr.j == 8) check("spot_k_s4j8", rom_k, 8);
        end
      end
      if (tw_valid) check("no_rom_req_while_valid", {rom_imag, rom_k}, 0);
      if (stall_prev)
        check("stall_hold", {tw_valid, tw_re, tw_im, tw_stage, tw_index}, {1'b1, held});
      if (tw_valid && !prev_valid) begin
        if (first_pair) check("first_valid_latency", cyc - start_cyc, 4);
        else            check("pair_interval", cyc - last_hs_cyc, 4);
        first_pair = 0;
        check("busy_with_valid", busy, 1);
      end
      if (tw_valid && tw_ready) begin
        if (exp_q.size() == 0) begin
          check("pair_count_overrun", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("pair_stage", tw_stage, e.s);
          check("pair_index", tw_index, e.j);
          check("pair_re", tw_re, e.re);
          check("pair_im", tw_im, e.im);
          if (e.s == 0 && e.j == 0)  check("spot_s0j0", {tw_re, tw_im}, 32'h7fff0000);
          if (e.s == 4 && e.j == 8)  check("spot_s4j8", {tw_re, tw_im}, 32'h00007fff);
          if (e.s == 4 && e.j == 12) check("spot_s4j12", {tw_re, tw_im}, 32'ha57e5a82);
          if (e.s == 3 && e.j == 5)  check("spot_s3j5", {tw_re, tw_im}, 32'hcf057641);
        end
        hs_count++;
        last_hs_cyc = cyc;
      end
      if (prev_done) check("done_single_pulse", {done, busy}, 0);
      if (done) begin
        done_count++;
        check("done_after_last_hs", cyc - last_hs_cyc, 1);
        check("done_pair_count", hs_count, NPAIRS);
        check("done_busy_low", busy, 0);
        check("done_queue_empty", exp_q.size(), 0);
      end
      stall_prev = tw_valid && !tw_ready;
      held       = {tw_re, tw_im, tw_stage, tw_index};
      prev_valid = tw_valid;
      prev_done  = done;
    end
    prev_rom_k    = rom_k;
    prev_rom_imag = rom_imag;
    rst_prev      = rst;
  end

  // One sweep: start pulse, spurious start at pair 20, optional 10-cycle stall at
  // pair 50, optional reset while pair rst_at is presented, random tw_ready.
  task automatic sweep(input int rst_at, input int ready_pct, input bit stall);
    int  base_done;
    int  stall_left;
    bit  did_start20;
    bit  did_stall;
    base_done   = done_count;
    stall_left  = 0;
    did_start20 = 0;
    did_stall   = 0;
    @(posedge clk); #2;
    start    = 1'b1;
    tw_ready = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      start = 1'b0;
      if (done_count != base_done) break;
      if (rst_at >= 0 && hs_count == rst_at && tw_valid) begin
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        return;
      end
      if (hs_count == 20 && !did_start20) begin
        start = 1'b1;
        did_start20 = 1;
      end
      if (stall && !did_stall && hs_count == 50 && tw_valid) begin
        stall_left = 10;
        did_stall = 1;
      end
      if (stall_left > 0) begin
        tw_ready = 1'b0;
        stall_left--;
      end else begin
        tw_ready = ($urandom_range(99) < ready_pct);
      end
    end
    if (done_count == base_done) tmo++;
    start    = 1'b0;
    tw_ready = 1'b1;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    tw_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    sweep(-1, 100, 1'b1);
    sweep(37, 100, 1'b0);
    sweep(-1, 65, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
